// File: rtl/vlan_tagger.sv
// ============================================================================
//  Module      : vlan_tagger
//  Description : Byte-stream 802.1Q tag inserter. Passes the 12 address bytes
//                of each frame, optionally inserts a 4-byte VLAN tag, then
//                passes the remainder. One registered output stage.
//                Optional macro VLAN_TAGGER_PAD_EN pads short frames with
//                0x00 up to 60 output bytes.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vlan_tagger (
   input  logic        clk,
   input  logic        rst,
   input  logic        tag_en,
   input  logic [2:0]  pcp,
   input  logic [11:0] vid,
   input  logic [7:0]  VLANi_tdata,
   input  logic        VLANi_tlast,
   input  logic        VLANi_tvalid,
   output logic        VLANi_tready,
   output logic [7:0]  VLANo_tdata,
   output logic        VLANo_tlast,
   output logic        VLANo_tvalid,
   input  logic        VLANo_tready
);

`ifdef VLAN_TAGGER_PAD_EN
   typedef enum logic [1:0] {
      ST_ADDR = 2'd0,
      ST_TAG  = 2'd1,
      ST_BODY = 2'd2,
      ST_PAD  = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_ADDR = 2'd0,
      ST_TAG  = 2'd1,
      ST_BODY = 2'd2
   } state_t;
`endif

   localparam logic [3:0] LAST_ADDR_IDX = 4'd11;
   localparam logic [3:0] LAST_TAG_IDX  = 4'd3;

   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;       // address byte index, reused as tag byte index
   logic        tag_en_q;
   logic [2:0]  pcp_q;
   logic [11:0] vid_q;

   logic        out_free;           // output register may take a new byte this cycle
   logic        accept;
   logic        ld;
   logic [7:0]  ld_data;
   logic        ld_last;
   logic [7:0]  tag_byte;

`ifdef VLAN_TAGGER_PAD_EN
   localparam logic [5:0] LAST_PAD_IDX = 6'd59;
   logic [5:0]  len_q;              // output bytes already emitted in this frame (saturating)
   logic        short_frame;
   assign short_frame = (len_q < LAST_PAD_IDX);
`endif

   assign out_free     = ~VLANo_tvalid | VLANo_tready;
   assign VLANi_tready = ~rst & out_free & ((state == ST_ADDR) | (state == ST_BODY));
   assign accept       = VLANi_tvalid & VLANi_tready;

   // Select the tag byte for the current insertion slot
   always_comb begin
      tag_byte = 8'h81;
      case (cnt[1:0])
         2'd0:    tag_byte = 8'h81;
         2'd1:    tag_byte = 8'h00;
         2'd2:    tag_byte = {pcp_q, 1'b0, vid_q[11:8]};
         default: tag_byte = vid_q[7:0];
      endcase
   end

   // Next-state logic and the byte to load into the output register
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      ld        = 1'b0;
      ld_data   = 8'h00;
      ld_last   = 1'b0;
      case (state)
         ST_ADDR: begin
            if (accept) begin
               ld      = 1'b1;
               ld_data = VLANi_tdata;
               ld_last = VLANi_tlast;
               if (VLANi_tlast) begin
                  // Frame too short to carry a tag: finish it untouched
                  cnt_nxt = 4'd0;
`ifdef VLAN_TAGGER_PAD_EN
                  if (short_frame) begin
                     ld_last   = 1'b0;
                     state_nxt = ST_PAD;
                  end
`endif
               end else if (cnt == LAST_ADDR_IDX) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = tag_en_q ? ST_TAG : ST_BODY;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         ST_TAG: begin
            if (out_free) begin
               ld      = 1'b1;
               ld_data = tag_byte;
               if (cnt == LAST_TAG_IDX) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_BODY;
               end else begin
                  cnt_nxt = cnt + 4'd1;
               end
            end
         end
         ST_BODY: begin
            if (accept) begin
               ld      = 1'b1;
               ld_data = VLANi_tdata;
               ld_last = VLANi_tlast;
               if (VLANi_tlast) begin
                  cnt_nxt   = 4'd0;
                  state_nxt = ST_ADDR;
`ifdef VLAN_TAGGER_PAD_EN
                  if (short_frame) begin
                     ld_last   = 1'b0;
                     state_nxt = ST_PAD;
                  end
`endif
               end
            end
         end
`ifdef VLAN_TAGGER_PAD_EN
         ST_PAD: begin
            if (out_free) begin
               ld      = 1'b1;
               ld_data = 8'h00;
               ld_last = (len_q == LAST_PAD_IDX);
               if (len_q == LAST_PAD_IDX) begin
                  state_nxt = ST_ADDR;
               end
            end
         end
`endif
         default: begin
            state_nxt = ST_ADDR;
            cnt_nxt   = 4'd0;
         end
      endcase
   end

   // FSM state and byte counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_ADDR;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Capture tag fields with the first byte of each frame
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_en_q <= 1'b0;
         pcp_q    <= 3'd0;
         vid_q    <= 12'd0;
      end else if (accept && (state == ST_ADDR) && (cnt == 4'd0)) begin
         tag_en_q <= tag_en;
         pcp_q    <= pcp;
         vid_q    <= vid;
      end
   end

   // Output register: load a new byte when free, otherwise hold under stall
   always_ff @(posedge clk) begin
      if (rst) begin
         VLANo_tvalid <= 1'b0;
         VLANo_tdata  <= 8'h00;
         VLANo_tlast  <= 1'b0;
      end else if (ld) begin
         VLANo_tvalid <= 1'b1;
         VLANo_tdata  <= ld_data;
         VLANo_tlast  <= ld_last;
      end else if (out_free) begin
         VLANo_tvalid <= 1'b0;
      end
   end

`ifdef VLAN_TAGGER_PAD_EN
   // Count output bytes of the current frame to decide on padding
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q <= 6'd0;
      end else if (ld) begin
         if (ld_last) begin
            len_q <= 6'd0;
         end else if (len_q != 6'd63) begin
            len_q <= len_q + 6'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vlan_tagger.sv
// ============================================================================
//  Module      : tb_vlan_tagger
//  Description : Scoreboard testbench for vlan_tagger. Expected output bytes
//                are queued when a frame's first byte is accepted and popped
//                as the DUT emits them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vlan_tagger;

   logic        clk = 1'b0;
   logic        rst;
   logic        tag_en;
   logic [2:0]  pcp;
   logic [11:0] vid;
   logic [7:0]  VLANi_tdata;
   logic        VLANi_tlast;
   logic        VLANi_tvalid;
   logic        VLANi_tready;
   logic [7:0]  VLANo_tdata;
   logic        VLANo_tlast;
   logic        VLANo_tvalid;
   logic        VLANo_tready;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [8:0]  exp_q[$];
   bit          sb_on = 1'b0;
   bit          rand_ready = 1'b0;
   int          first_in_edge = 0;
   int          last_in_edge = 0;
   int          last_out_edge = 0;
   logic [8:0]  held = 9'h0;
   bit          stalled = 1'b0;

   vlan_tagger dut (
      .clk          (clk),
      .rst          (rst),
      .tag_en       (tag_en),
      .pcp          (pcp),
      .vid          (vid),
      .VLANi_tdata  (VLANi_tdata),
      .VLANi_tlast  (VLANi_tlast),
      .VLANi_tvalid (VLANi_tvalid),
      .VLANi_tready (VLANi_tready),
      .VLANo_tdata  (VLANo_tdata),
      .VLANo_tlast  (VLANo_tlast),
      .VLANo_tvalid (VLANo_tvalid),
      .VLANo_tready (VLANo_tready)
   );

   always #5 clk = ~clk;

   // Edge counter
   always @(posedge clk) cyc++;

   // Downstream ready: always 1 or 50% random
   always @(posedge clk) begin
      #1;
      VLANo_tready = rand_ready ? ($urandom_range(1) == 1) : 1'b1;
   end

   // Output monitor: stall stability and scoreboard comparison
   always @(negedge clk) begin
      if (sb_on && !rst) begin
         if (stalled) begin
            checks++;
            if (VLANo_tvalid !== 1'b1 || {VLANo_tlast, VLANo_tdata} !== held) begin
               errors++;
               $display("FAIL stall_stable: got valid=%b last/data=%h, required valid=1 last/data=%h",
                        VLANo_tvalid, {VLANo_tlast, VLANo_tdata}, held);
            end
         end
         stalled = (VLANo_tvalid === 1'b1) && (VLANo_tready === 1'b0);
         held    = {VLANo_tlast, VLANo_tdata};
         if (VLANo_tvalid === 1'b1 && VLANo_tready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got last/data=%h, required none", {VLANo_tlast, VLANo_tdata});
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               if ({VLANo_tlast, VLANo_tdata} !== e) begin
                  errors++;
                  $display("FAIL out_byte: got last/data=%h, required %h", {VLANo_tlast, VLANo_tdata}, e);
               end
            end
            if (VLANo_tlast === 1'b1) last_out_edge = cyc + 1;
         end
      end else begin
         stalled = 1'b0;
      end
   end

   // Reference model: expected output of one frame
   task automatic push_frame(input int len, input logic [7:0] start, input logic te,
                             input logic [2:0] p, input logic [11:0] v);
      logic [8:0] q[$];
      logic [7:0] b2;
      b2 = {p, 1'b0, v[11:8]};
      for (int i = 0; i < len; i++) begin
         if (te && len > 12 && i == 12) begin
            q.push_back({1'b0, 8'h81});
            q.push_back({1'b0, 8'h00});
            q.push_back({1'b0, b2});
            q.push_back({1'b0, v[7:0]});
         end
         q.push_back({1'b0, 8'(start + 8'(i))});
      end
`ifdef VLAN_TAGGER_PAD_EN
      while (q.size() < 60) q.push_back(9'h000);
`endif
      q[q.size()-1][8] = 1'b1;
      foreach (q[k]) exp_q.push_back(q[k]);
   endtask

   task automatic send_frame(input int len, input logic [7:0] start, input logic te,
                             input logic [2:0] p, input logic [11:0] v,
                             input bit rnd, input bit toggle);
      bit acc;
      int waits;
      tag_en = te;
      pcp    = p;
      vid    = v;
      for (int i = 0; i < len; i++) begin
         if (rnd) begin
            while ($urandom_range(1) == 0) begin
               VLANi_tvalid = 1'b0;
               @(posedge clk); #1;
            end
         end
         VLANi_tvalid = 1'b1;
         VLANi_tdata  = 8'(start + 8'(i));
         VLANi_tlast  = (i == len - 1);
         acc   = 1'b0;
         waits = 0;
         while (!acc) begin
            @(negedge clk);
            acc = (VLANi_tready === 1'b1);
            if (acc) begin
               if (i == 0) begin
                  push_frame(len, start, te, p, v);
                  first_in_edge = cyc + 1;
               end
               last_in_edge = cyc + 1;
            end
            @(posedge clk); #1;
            waits++;
            if (!acc && waits > 1000) begin
               checks++;
               errors++;
               $display("FAIL input_timeout: got no accept after %0d cycles, required accept", waits);
               VLANi_tvalid = 1'b0;
               return;
            end
         end
         if (toggle && i == 0) tag_en = ~te;
      end
      VLANi_tvalid = 1'b0;
      VLANi_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d bytes outstanding, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      VLANi_tvalid = 1'b1;
      VLANi_tdata  = 8'h55;
      VLANi_tlast  = 1'b0;
      tag_en = 1'b0; pcp = 3'd0; vid = 12'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (VLANi_tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_tready: got %b, required 0", VLANi_tready);
      end
      checks++;
      if (VLANo_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_tvalid: got %b, required 0", VLANo_tvalid);
      end
      checks++;
      if (VLANo_tdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_tdata: got %h, required 00", VLANo_tdata);
      end
      checks++;
      if (VLANo_tlast !== 1'b0) begin
         errors++;
         $display("FAIL reset_tlast: got %b, required 0", VLANo_tlast);
      end
      @(posedge clk); #1;
      rst          = 1'b0;
      VLANi_tvalid = 1'b0;
      sb_on        = 1'b1;
   endtask

   task automatic test_tagged();
      send_frame(20, 8'h01, 1'b1, 3'd5, 12'h123, 1'b0, 1'b0);
      wait_drain();
      checks++;
      if (last_in_edge - first_in_edge + 1 != 24) begin
         errors++;
         $display("FAIL tagged_input_span: got %0d, required 24", last_in_edge - first_in_edge + 1);
      end
   endtask

   task automatic test_untagged();
      send_frame(20, 8'h01, 1'b0, 3'd5, 12'h123, 1'b0, 1'b0);
      wait_drain();
      checks++;
      if (last_in_edge - first_in_edge + 1 != 20) begin
         errors++;
         $display("FAIL untagged_input_span: got %0d, required 20", last_in_edge - first_in_edge + 1);
      end
`ifndef VLAN_TAGGER_PAD_EN
      checks++;
      if (last_out_edge != last_in_edge + 1) begin
         errors++;
         $display("FAIL untagged_latency: got %0d, required %0d", last_out_edge, last_in_edge + 1);
      end
`endif
   endtask

   task automatic test_short();
      send_frame(8, 8'hA0, 1'b1, 3'd7, 12'hFFF, 1'b0, 1'b0);
      wait_drain();
      send_frame(12, 8'hB0, 1'b1, 3'd1, 12'h001, 1'b0, 1'b0);
      wait_drain();
      send_frame(13, 8'hC0, 1'b1, 3'd3, 12'h5A5, 1'b0, 1'b0);
      wait_drain();
   endtask

   task automatic test_back_to_back();
      int prev_last;
      send_frame(16, 8'h10, 1'b0, 3'd0, 12'h000, 1'b0, 1'b0);
      prev_last = last_in_edge;
      send_frame(16, 8'h30, 1'b0, 3'd0, 12'h000, 1'b0, 1'b0);
      checks++;
      if (first_in_edge != prev_last + 1) begin
         errors++;
         $display("FAIL back_to_back_gap: got first edge %0d, required %0d", first_in_edge, prev_last + 1);
      end
      wait_drain();
      rand_ready = 1'b1;
      send_frame(20, 8'h50, 1'b1, 3'd6, 12'h7E1, 1'b1, 1'b1);
      send_frame(15, 8'h70, 1'b0, 3'd2, 12'h222, 1'b1, 1'b1);
      send_frame(30, 8'h90, 1'b1, 3'd4, 12'hC3C, 1'b1, 1'b1);
      wait_drain();
      rand_ready = 1'b0;
   endtask

   task automatic test_reset_midframe();
      bit acc;
      int waits;
      sb_on  = 1'b0;
      tag_en = 1'b1; pcp = 3'd5; vid = 12'h123;
      for (int i = 0; i < 13; i++) begin
         VLANi_tvalid = 1'b1;
         VLANi_tdata  = 8'(i + 1);
         VLANi_tlast  = 1'b0;
         acc   = 1'b0;
         waits = 0;
         while (!acc && waits < 100) begin
            @(negedge clk);
            acc = (VLANi_tready === 1'b1);
            @(posedge clk); #1;
            waits++;
         end
      end
      VLANi_tdata = 8'd14;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (VLANi_tready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_tready: got %b, required 0", VLANi_tready);
      end
      @(posedge clk); #1;
      checks++;
      if (VLANo_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL midreset_tvalid: got %b, required 0", VLANo_tvalid);
      end
      rst          = 1'b0;
      VLANi_tvalid = 1'b0;
      exp_q.delete();
      sb_on = 1'b1;
      send_frame(20, 8'h41, 1'b1, 3'd2, 12'hABC, 1'b0, 1'b0);
      wait_drain();
   endtask

   initial begin
      VLANo_tready = 1'b1;
      test_reset();
      test_tagged();
      test_untagged();
      test_short();
      test_back_to_back();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vlan_tagger.md
VLAN_TAGGER -- requirements
Module: vlan_tagger

Interface
REQ-001 SHALL have the following parameter: none; runtime tag fields are input ports.
REQ-002 SHALL provide the following ports (name, direction, width, meaning):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tag_en  in  1  1 = insert 802.1Q tag into the next frame
- pcp  in  3  priority code point for the inserted tag
- vid  in  12  VLAN ID for the inserted tag
- VLANi_tdata  in  8  input stream byte, fed by L23_buffer L23o_tdata
- VLANi_tlast  in  1  last byte of input frame
- VLANi_tvalid  in  1  input byte valid
- VLANi_tready  out  1  input byte accepted when tvalid & tready
- VLANo_tdata  out  8  output stream byte
- VLANo_tlast  out  1  last byte of output frame
- VLANo_tvalid  out  1  output byte valid
- VLANo_tready  in  1  downstream ready

Function
REQ-003 Byte transfer SHALL occur only on a rising edge with tvalid & tready high, on both ports.
REQ-004 Output SHALL be one registered stage: accepted byte appears on VLANo_* the next cycle; latency 1 cycle.
REQ-005 VLANi_tready SHALL equal (~VLANo_tvalid | VLANo_tready) in ADDR, BODY; 0 in TAG (and PAD).
REQ-006 VLANo_tvalid/tdata/tlast SHALL hold stable while VLANo_tvalid & ~VLANo_tready.
REQ-007 FSM states: ADDR, TAG, BODY (PAD when configured); reset state ADDR.
REQ-008 tag_en, pcp, vid SHALL be sampled on acceptance of the first byte of each frame and held for that frame.
REQ-009 ADDR: pass bytes, 4-bit counter increments per accepted byte; after 12th byte, go to TAG if sampled tag_en=1, else BODY.
REQ-010 TAG: emit 4 bytes 0x81, 0x00, {pcp,1'b0,vid[11:8]}, vid[7:0], one per output slot, tlast=0; then BODY.
REQ-011 BODY: pass bytes unchanged; on accepted tlast byte go to ADDR, counter cleared.
REQ-012 Frame ending (tlast) at or before byte 12 SHALL be passed unchanged, untagged, FSM back to ADDR.
REQ-013 tlast SHALL be forwarded only with its own byte; inserted tag bytes never carry tlast.
REQ-014 Back-to-back frames SHALL have no idle cycle between tlast and next first byte when both sides are ready.
REQ-015 Throughput SHALL be 1 byte/cycle except for the 4 tag-insertion cycles.

Reset
REQ-016 While rst=1 on a rising edge: FSM=ADDR, counters=0, VLANo_tvalid=0, VLANo_tdata=0x00, VLANo_tlast=0, sampled fields=0.
REQ-017 VLANi_tready SHALL be 0 during reset cycles.
REQ-018 Reset asserted mid-frame SHALL discard partial frame; next accepted byte after reset is treated as first byte.

Configuration
REQ-019 Macro VLAN_TAGGER_PAD_EN SHALL enable state PAD.
REQ-020 With VLAN_TAGGER_PAD_EN defined: frame whose output length <60 bytes SHALL have its input tlast suppressed, then 0x00 bytes appended until output byte 60, which carries tlast; VLANi_tready=0 in PAD.
REQ-021 Without VLAN_TAGGER_PAD_EN: no padding, output length = input length (+4 if tagged), no PAD state or length counter synthesized.

Verification
REQ-022 tag_en=1, pcp=5, vid=0x123, 20-byte frame 0x01..0x14, tready always 1 -> output 0x01..0x0C, 81 00 A1 23, 0x0D..0x14, tlast on 0x14, 24 bytes.
REQ-023 tag_en=0, same frame -> identical 20 bytes out, latency 1 cycle, no bubbles.
REQ-024 8-byte frame with tag_en=1 -> 8 bytes unchanged, no tag (PAD_EN undefined); 60 bytes ending 0x00 with tlast (PAD_EN defined).
REQ-025 Random tvalid/tready (50%) over 3 back-to-back frames with tag_en toggled mid-frame -> tagging follows value sampled at each first byte; no loss, duplication or reordering; outputs stable under stall.
REQ-026 rst pulsed one cycle during byte 14 of a tagged frame -> VLANo_tvalid=0 next cycle; following 20-byte frame tagged correctly from its first byte.
